// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// buffers fetched {word, PC} pairs in a 2-entry FIFO handed to decode via valid/ready.
module instruction_fetch_unit #(
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Branch_Valid_i,
  input  logic [DATA_WIDTH-1:0] Branch_Target_i,
  output logic                  Instr_Valid_o,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] Instr_PC_o,
  input  logic                  Instr_Ready_i,
  output logic                  Fault_o
);

  localparam logic [DATA_WIDTH-1:0] REGION_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  // PCs below TEXT_BASE wrap to huge offsets under the unsigned subtraction.
  function automatic logic is_legal(input logic [DATA_WIDTH-1:0] pc);
    logic [DATA_WIDTH-1:0] offset;
    offset = pc - TEXT_BASE;
    return (pc[1:0] == 2'b00) && (offset < REGION_BYTES);
  endfunction

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  fault_q, fault_d;
  logic [1:0]            count_q, count_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] entry_word_q [2];
  logic [DATA_WIDTH-1:0] entry_word_d [2];
  logic [DATA_WIDTH-1:0] entry_pc_q [2];
  logic [DATA_WIDTH-1:0] entry_pc_d [2];

  logic pc_legal;
  logic pop;
  logic fetch;

  always_comb begin
    pc_legal     = is_legal(pc_q);
    pop          = (count_q != 2'd0) && Instr_Ready_i;
    fetch        = pc_legal && ((count_q != 2'd2) || pop) && !Branch_Valid_i;
    pc_d         = pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    entry_word_d = entry_word_q;
    entry_pc_d   = entry_pc_q;

    // A redirect flushes everything, including an entry popped in the same cycle.
    if (Branch_Valid_i) begin
      pc_d    = Branch_Target_i;
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (fetch) begin
        entry_word_d[tail_q] = Instruction_i;
        entry_pc_d[tail_q]   = pc_q;
        tail_d               = ~tail_q;
        pc_d                 = pc_q + DATA_WIDTH'(4);
      end
      if (pop) begin
        head_d = ~head_q;
      end
      case ({fetch, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end

    fault_d = !is_legal(pc_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= TEXT_BASE;
      fault_q      <= 1'b0;
      count_q      <= 2'd0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      entry_word_q <= '{default: '0};
      entry_pc_q   <= '{default: '0};
    end else begin
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      entry_word_q <= entry_word_d;
      entry_pc_q   <= entry_pc_d;
    end
  end

  assign Address_o     = pc_q;
  assign Fault_o       = fault_q;
  assign Instr_Valid_o = (count_q != 2'd0);
  assign Instr_o       = entry_word_q[head_q];
  assign Instr_PC_o    = entry_pc_q[head_q];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; the ROM model returns
// word == address so every fetched word equals its own PC.
module tb_instruction_fetch_unit;

   logic        clock;
   logic        reset;
   logic [31:0] addressOut;
   logic [31:0] instructionIn;
   logic        branchValid;
   logic [31:0] branchTarget;
   logic        instrValid;
   logic [31:0] instrWord;
   logic [31:0] instrPc;
   logic        instrReady;
   logic        fault;

   int checkCount;
   int errorCount;

   instruction_fetch_unit #(
      .DATA_WIDTH  (32),
      .MEMORY_DEPTH(64),
      .TEXT_BASE   (32'h0040_0000)
   ) dut (
      .clk            (clock),
      .reset          (reset),
      .Address_o      (addressOut),
      .Instruction_i  (instructionIn),
      .Branch_Valid_i (branchValid),
      .Branch_Target_i(branchTarget),
      .Instr_Valid_o  (instrValid),
      .Instr_o        (instrWord),
      .Instr_PC_o     (instrPc),
      .Instr_Ready_i  (instrReady),
      .Fault_o        (fault)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Combinational ROM: the word at each address is the address itself.
   assign instructionIn = addressOut;

   // Drive one cycle of inputs, then let the edge happen and settle before sampling.
   task automatic applyStimulus(input logic rst, input logic ready,
                                input logic bv, input logic [31:0] target);
      reset        = rst;
      instrReady   = ready;
      branchValid  = bv;
      branchTarget = target;
      @(posedge clock);
      #1;
   endtask

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Directed sequence: reset, streaming, backpressure, flush, end of region,
   // fault recovery and reset during streaming.
   initial begin
      checkCount   = 0;
      errorCount   = 0;
      reset        = 1'b1;
      instrReady   = 1'b0;
      branchValid  = 1'b0;
      branchTarget = 32'h0;

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("reset_addr",  addressOut,        32'h0040_0000);
      checkOutput("reset_valid", {31'b0, instrValid}, 32'd0);
      checkOutput("reset_instr", instrWord,         32'h0);
      checkOutput("reset_pc",    instrPc,           32'h0);
      checkOutput("reset_fault", {31'b0, fault},    32'd0);

      // Streaming with ready high: head PC lags the fetch address by one word.
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         checkOutput("stream_addr",  addressOut, 32'h0040_0000 + 32'(4 * k));
         checkOutput("stream_valid", {31'b0, instrValid}, 32'd1);
         checkOutput("stream_pc",    instrPc,    32'h0040_0000 + 32'(4 * (k - 1)));
         checkOutput("stream_instr", instrWord,  32'h0040_0000 + 32'(4 * (k - 1)));
      end

      // Backpressure: buffer fills to two, PC freezes, head holds steady.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         checkOutput("bp_addr",  addressOut, 32'h0040_0014);
         checkOutput("bp_valid", {31'b0, instrValid}, 32'd1);
         checkOutput("bp_head",  instrPc,    32'h0040_000C);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("bp_release_head1", instrPc,    32'h0040_0010);
      checkOutput("bp_release_addr1", addressOut, 32'h0040_0018);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("bp_release_head2", instrPc,    32'h0040_0014);
      checkOutput("bp_release_addr2", addressOut, 32'h0040_001C);

      // Flush with two entries buffered and a pop in the same cycle.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_0040);
      checkOutput("flush_valid", {31'b0, instrValid}, 32'd0);
      checkOutput("flush_addr",  addressOut,          32'h0040_0040);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("flush_first_valid", {31'b0, instrValid}, 32'd1);
      checkOutput("flush_first_pc",    instrPc,             32'h0040_0040);
      checkOutput("flush_first_instr", instrWord,           32'h0040_0040);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("flush_second_pc",   instrPc,             32'h0040_0044);

      // End of region: last legal word, then fault and drain.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_00FC);
      checkOutput("eor_redirect_addr",  addressOut,         32'h0040_00FC);
      checkOutput("eor_redirect_fault", {31'b0, fault},     32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("eor_addr",  addressOut,          32'h0040_0100);
      checkOutput("eor_fault", {31'b0, fault},      32'd1);
      checkOutput("eor_valid", {31'b0, instrValid}, 32'd1);
      checkOutput("eor_pc",    instrPc,             32'h0040_00FC);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("eor_drained", {31'b0, instrValid}, 32'd0);
      checkOutput("eor_hold1",   addressOut,          32'h0040_0100);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("eor_hold2",   addressOut,          32'h0040_0100);
      checkOutput("eor_fault2",  {31'b0, fault},      32'd1);

      // Fault recovery: out-of-region and misaligned targets keep the fault.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h1001_0000);
      checkOutput("rec_far_addr",  addressOut,     32'h1001_0000);
      checkOutput("rec_far_fault", {31'b0, fault}, 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rec_far_hold",  addressOut,          32'h1001_0000);
      checkOutput("rec_far_valid", {31'b0, instrValid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_0002);
      checkOutput("rec_misaligned_fault", {31'b0, fault}, 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h003F_FFFC);
      checkOutput("rec_below_base_fault", {31'b0, fault}, 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_0000);
      checkOutput("rec_legal_fault", {31'b0, fault},      32'd0);
      checkOutput("rec_legal_addr",  addressOut,          32'h0040_0000);
      checkOutput("rec_legal_valid", {31'b0, instrValid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rec_resume_pc",   instrPc,    32'h0040_0000);
      checkOutput("rec_resume_addr", addressOut, 32'h0040_0004);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rec_resume_pc2",  instrPc,    32'h0040_0004);

      // Reset during streaming overrides a simultaneous redirect.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040_0080);
      checkOutput("midreset_addr",  addressOut,          32'h0040_0000);
      checkOutput("midreset_valid", {31'b0, instrValid}, 32'd0);
      checkOutput("midreset_instr", instrWord,           32'h0);
      checkOutput("midreset_pc",    instrPc,             32'h0);
      checkOutput("midreset_fault", {31'b0, fault},      32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("postreset_pc",   instrPc,    32'h0040_0000);
      checkOutput("postreset_addr", addressOut, 32'h0040_0004);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
